// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the unified memory port arbiter
// Contents: arb_state_t FSM encoding, owner_t grant owner encoding,
//           NOP_INSTR (addi x0,x0,0), default address/data widths.
package mem_port_arbiter_pkg;

   localparam int          DEFAULT_AW = 32;
   localparam int          DEFAULT_DW = 32;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_DM = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - wait-cycle watchdog and sticky bus error flag for the memory port
// Parameters: TIMEOUT - waiting cycles tolerated before forcing completion (0 = disabled)
// Ports:
//   clk       in   clock
//   reset     in   asynchronous active-low reset
//   mem_req   in   memory request currently outstanding
//   mem_ready in   memory completion this cycle
//   timeout   out  force completion this cycle (combinational)
//   bus_err   out  sticky error, cleared only by reset
module mem_arb_watchdog
#(
   parameter int TIMEOUT = 255
)
(
   input  logic clk,
   input  logic reset,
   input  logic mem_req,
   input  logic mem_ready,
   output logic timeout,
   output logic bus_err
);

   generate
      if (TIMEOUT > 0) begin : g_wd
         localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

         logic [CW-1:0] cnt;
         logic          waiting;

         assign waiting = mem_req & ~mem_ready;
         // Fires in the waiting cycle that would bring the count to TIMEOUT,
         // so the owner completes after exactly TIMEOUT unanswered cycles.
         assign timeout = waiting && (cnt == CW'(TIMEOUT - 1));

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               cnt     <= '0;
               bus_err <= 1'b0;
            end else begin
               if (waiting && !timeout) begin
                  cnt <= cnt + 1'b1;
               end else begin
                  cnt <= '0;
               end
               if (timeout) begin
                  bus_err <= 1'b1;
               end
            end
         end
      end else begin : g_no_wd
         assign timeout = 1'b0;
         assign bus_err = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and data ports onto one single-port memory
// Optional feature macro: MEM_PORT_ARBITER_PERF_EN (stall/drop performance counters)
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   if_req/if_addr                 fetch request and PC
//   if_rdata/if_valid/if_stall     fetch result, completion pulse, stall request
//   flush_if                       taken branch, kills the outstanding fetch
//   dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb  data access request
//   dm_rdata/dm_valid/dm_stall     load result, completion pulse, stall request
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  registered memory request
//   mem_ready/mem_rdata            memory completion and read data
//   bus_err                        sticky watchdog error
//   perf_*                         performance counters (macro only)
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW      = DEFAULT_AW,
   parameter int DW      = DEFAULT_DW,
   parameter int TIMEOUT = 255
)
(
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic [DW-1:0]   if_rdata,
   output logic            if_valid,
   output logic            if_stall,
   input  logic            flush_if,
   input  logic            dm_req,
   input  logic            dm_we,
   input  logic [AW-1:0]   dm_addr,
   input  logic [DW-1:0]   dm_wdata,
   input  logic [DW/8-1:0] dm_wstrb,
   output logic [DW-1:0]   dm_rdata,
   output logic            dm_valid,
   output logic            dm_stall,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wstrb,
   input  logic            mem_ready,
   input  logic [DW-1:0]   mem_rdata,
   output logic            bus_err
`ifdef MEM_PORT_ARBITER_PERF_EN
   ,
   output logic [31:0]     perf_if_stall_cycles,
   output logic [31:0]     perf_dm_stall_cycles,
   output logic [31:0]     perf_if_dropped
`endif
);

   arb_state_t    state;
   arb_state_t    state_n;
   logic          grant;
   owner_t        grant_owner;
   logic          complete;
   logic          timeout;
   logic          drop_q;
   logic          if_kill;
   logic          if_done;
   logic          dm_done;
   logic [DW-1:0] rsp_data;

   // Stalls are gated by reset so every output reads 0 while reset is held.
   // Masking with the valid pulse also keeps a held request from being
   // granted a second time in its completion cycle.
   assign if_stall = reset & if_req & ~if_valid;
   assign dm_stall = reset & dm_req & ~dm_valid;

   assign complete = mem_req & (mem_ready | timeout);
   assign if_done  = complete && (state == IF_BUSY);
   assign dm_done  = complete && (state == DM_BUSY);
   assign if_kill  = flush_if | drop_q;
   assign rsp_data = timeout ? '0 : mem_rdata;

   mem_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_ready (mem_ready),
      .timeout   (timeout),
      .bus_err   (bus_err)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Data port wins in IDLE: the MEM-stage instruction is the older one.
   always_comb begin
      state_n     = state;
      grant       = 1'b0;
      grant_owner = OWNER_IF;
      case (state)
         IDLE: begin
            if (dm_stall) begin
               grant       = 1'b1;
               grant_owner = OWNER_DM;
               state_n     = DM_BUSY;
            end else if (if_stall) begin
               grant       = 1'b1;
               grant_owner = OWNER_IF;
               state_n     = IF_BUSY;
            end
         end
         IF_BUSY, DM_BUSY: begin
            if (complete) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         if_rdata  <= '0;
         if_valid  <= 1'b0;
         dm_rdata  <= '0;
         dm_valid  <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         dm_valid <= 1'b0;
         mem_req  <= (state_n != IDLE);

         if (grant) begin
            if (grant_owner == OWNER_DM) begin
               mem_we    <= dm_we;
               mem_addr  <= dm_addr;
               mem_wdata <= dm_wdata;
               mem_wstrb <= dm_wstrb;
            end else begin
               mem_we    <= 1'b0;
               mem_addr  <= if_addr;
               mem_wdata <= '0;
               mem_wstrb <= '0;
            end
         end

         if (dm_done) begin
            dm_rdata <= rsp_data;
            dm_valid <= 1'b1;
         end

         // A killed fetch still finishes on the bus but is never reported,
         // and the previous instruction word is kept.
         if (if_done && !if_kill) begin
            if_rdata <= rsp_data;
            if_valid <= 1'b1;
         end

         if (if_done) begin
            drop_q <= 1'b0;
         end else if (flush_if && ((state == IF_BUSY) ||
                                   (grant && grant_owner == OWNER_IF))) begin
            drop_q <= 1'b1;
         end
      end
   end

`ifdef MEM_PORT_ARBITER_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_if_stall_cycles <= '0;
         perf_dm_stall_cycles <= '0;
         perf_if_dropped      <= '0;
      end else begin
         if (if_stall && (perf_if_stall_cycles != '1)) begin
            perf_if_stall_cycles <= perf_if_stall_cycles + 1'b1;
         end
         if (dm_stall && (perf_dm_stall_cycles != '1)) begin
            perf_dm_stall_cycles <= perf_dm_stall_cycles + 1'b1;
         end
         if (if_done && if_kill && (perf_if_dropped != '1)) begin
            perf_if_dropped <= perf_if_dropped + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk;
   logic            reset;
   logic            if_req;
   logic [AW-1:0]   if_addr;
   logic [DW-1:0]   if_rdata;
   logic            if_valid;
   logic            if_stall;
   logic            flush_if;
   logic            dm_req;
   logic            dm_we;
   logic [AW-1:0]   dm_addr;
   logic [DW-1:0]   dm_wdata;
   logic [DW/8-1:0] dm_wstrb;
   logic [DW-1:0]   dm_rdata;
   logic            dm_valid;
   logic            dm_stall;
   logic            mem_req;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW/8-1:0] mem_wstrb;
   logic            mem_ready;
   logic [DW-1:0]   mem_rdata;
   logic            bus_err;
`ifdef MEM_PORT_ARBITER_PERF_EN
   logic [31:0]     perf_if_stall_cycles;
   logic [31:0]     perf_dm_stall_cycles;
   logic [31:0]     perf_if_dropped;
`endif

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   mem_port_arbiter #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .if_stall  (if_stall),
      .flush_if  (flush_if),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_wstrb  (dm_wstrb),
      .dm_rdata  (dm_rdata),
      .dm_valid  (dm_valid),
      .dm_stall  (dm_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .bus_err   (bus_err)
`ifdef MEM_PORT_ARBITER_PERF_EN
      ,
      .perf_if_stall_cycles (perf_if_stall_cycles),
      .perf_dm_stall_cycles (perf_dm_stall_cycles),
      .perf_if_dropped      (perf_if_dropped)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Each cycle: move to the falling edge, drive that cycle's inputs,
   // settle, then check.
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      reset     = 1'b0;
      if_req    = 1'b0;
      if_addr   = '0;
      flush_if  = 1'b0;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      dm_addr   = '0;
      dm_wdata  = '0;
      dm_wstrb  = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;

      // Reset state
      cyc(); cyc(); #1;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_dm_valid", 32'(dm_valid), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      cyc(); reset = 1'b1;

      // 1: lone fetch, zero-wait memory
      cyc(); if_req = 1'b1; if_addr = 32'h100; #1;
      chk("t1_c0_if_stall", 32'(if_stall), 32'd1);
      chk("t1_c0_mem_req", 32'(mem_req), 32'd0);
      cyc(); mem_ready = 1'b1; mem_rdata = 32'h0050_0093; #1;
      chk("t1_c1_mem_req", 32'(mem_req), 32'd1);
      chk("t1_c1_mem_addr", mem_addr, 32'h100);
      chk("t1_c1_mem_we", 32'(mem_we), 32'd0);
      chk("t1_c1_if_stall", 32'(if_stall), 32'd1);
      cyc(); mem_ready = 1'b0; #1;
      chk("t1_c2_if_valid", 32'(if_valid), 32'd1);
      chk("t1_c2_if_rdata", if_rdata, 32'h0050_0093);
      chk("t1_c2_if_stall", 32'(if_stall), 32'd0);
      chk("t1_c2_mem_req", 32'(mem_req), 32'd0);
      if_req = 1'b0;
      cyc(); #1;
      chk("t1_c3_if_valid", 32'(if_valid), 32'd0);
      chk("t1_c3_if_rdata_hold", if_rdata, 32'h0050_0093);

      // 2: fetch and load together, data first
      cyc(); if_req = 1'b1; if_addr = 32'h104; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; #1;
      chk("t2_c0_if_stall", 32'(if_stall), 32'd1);
      chk("t2_c0_dm_stall", 32'(dm_stall), 32'd1);
      cyc(); mem_ready = 1'b1; mem_rdata = 32'h1111_2222; #1;
      chk("t2_c1_mem_addr", mem_addr, 32'h2000);
      chk("t2_c1_mem_req", 32'(mem_req), 32'd1);
      chk("t2_c1_if_stall", 32'(if_stall), 32'd1);
      cyc(); mem_ready = 1'b0; #1;
      chk("t2_c2_dm_valid", 32'(dm_valid), 32'd1);
      chk("t2_c2_dm_rdata", dm_rdata, 32'h1111_2222);
      chk("t2_c2_if_stall", 32'(if_stall), 32'd1);
      chk("t2_c2_if_valid", 32'(if_valid), 32'd0);
      dm_req = 1'b0;
      cyc(); mem_ready = 1'b1; mem_rdata = 32'h3333_4444; #1;
      chk("t2_c3_mem_req", 32'(mem_req), 32'd1);
      chk("t2_c3_mem_addr", mem_addr, 32'h104);
      chk("t2_c3_dm_valid", 32'(dm_valid), 32'd0);
      cyc(); mem_ready = 1'b0; #1;
      chk("t2_c4_if_valid", 32'(if_valid), 32'd1);
      chk("t2_c4_if_rdata", if_rdata, 32'h3333_4444);
      if_req = 1'b0;

      // 3: store with three wait states
      cyc(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3000; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'b0011; mem_rdata = '0; #1;
      for (int i = 1; i <= 4; i++) begin
         cyc(); mem_ready = (i == 4); #1;
         chk($sformatf("t3_c%0d_mem_req", i), 32'(mem_req), 32'd1);
         chk($sformatf("t3_c%0d_mem_we", i), 32'(mem_we), 32'd1);
         chk($sformatf("t3_c%0d_mem_addr", i), mem_addr, 32'h3000);
         chk($sformatf("t3_c%0d_mem_wdata", i), mem_wdata, 32'hDEAD_BEEF);
         chk($sformatf("t3_c%0d_mem_wstrb", i), 32'(mem_wstrb), 32'h3);
         chk($sformatf("t3_c%0d_dm_valid", i), 32'(dm_valid), 32'd0);
      end
      cyc(); mem_ready = 1'b0; #1;
      chk("t3_c5_dm_valid", 32'(dm_valid), 32'd1);
      chk("t3_c5_if_valid", 32'(if_valid), 32'd0);
      chk("t3_c5_mem_req", 32'(mem_req), 32'd0);
      chk("t3_c5_bus_err", 32'(bus_err), 32'd0);
      dm_req = 1'b0; dm_we = 1'b0;
      cyc(); #1;
      chk("t3_c6_dm_valid", 32'(dm_valid), 32'd0);

      // 4: flush during IF_BUSY, then refetch at 0x40
      cyc(); if_req = 1'b1; if_addr = 32'h200; #1;
      cyc(); flush_if = 1'b1; #1;
      chk("t4_c1_mem_addr", mem_addr, 32'h200);
      cyc(); flush_if = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0000_0BAD; if_addr = 32'h40; #1;
      chk("t4_c2_mem_req", 32'(mem_req), 32'd1);
      cyc(); mem_ready = 1'b0; #1;
      chk("t4_c3_if_valid", 32'(if_valid), 32'd0);
      chk("t4_c3_if_rdata_hold", if_rdata, 32'h3333_4444);
      chk("t4_c3_if_stall", 32'(if_stall), 32'd1);
      cyc(); mem_ready = 1'b1; mem_rdata = 32'h1234_5678; #1;
      chk("t4_c4_mem_addr", mem_addr, 32'h40);
      chk("t4_c4_mem_req", 32'(mem_req), 32'd1);
      cyc(); mem_ready = 1'b0; #1;
      chk("t4_c5_if_valid", 32'(if_valid), 32'd1);
      chk("t4_c5_if_rdata", if_rdata, 32'h1234_5678);
      if_req = 1'b0;

      // 5: memory never answers, TIMEOUT=4
      cyc(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h5000; mem_rdata = 32'hFFFF_FFFF; #1;
      for (int i = 1; i <= 4; i++) begin
         cyc(); #1;
         chk($sformatf("t5_c%0d_mem_req", i), 32'(mem_req), 32'd1);
         chk($sformatf("t5_c%0d_bus_err", i), 32'(bus_err), 32'd0);
      end
      cyc(); #1;
      chk("t5_c5_bus_err", 32'(bus_err), 32'd1);
      chk("t5_c5_dm_valid", 32'(dm_valid), 32'd1);
      chk("t5_c5_dm_rdata", dm_rdata, 32'h0);
      chk("t5_c5_mem_req", 32'(mem_req), 32'd0);
      dm_req = 1'b0;
      cyc(); cyc(); #1;
      chk("t5_sticky_bus_err", 32'(bus_err), 32'd1);
      chk("t5_dm_valid_low", 32'(dm_valid), 32'd0);

      // 6: asynchronous reset in the middle of DM_BUSY
      cyc(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h6000; dm_wdata = 32'hCAFE_F00D; dm_wstrb = 4'hF; #1;
      cyc(); #1;
      chk("t6_c1_mem_req", 32'(mem_req), 32'd1);
      chk("t6_c1_mem_addr", mem_addr, 32'h6000);
      #1 reset = 1'b0; #1;
      chk("t6_async_mem_req", 32'(mem_req), 32'd0);
      chk("t6_async_mem_we", 32'(mem_we), 32'd0);
      chk("t6_async_mem_addr", mem_addr, 32'h0);
      chk("t6_async_mem_wdata", mem_wdata, 32'h0);
      chk("t6_async_mem_wstrb", 32'(mem_wstrb), 32'h0);
      chk("t6_async_bus_err", 32'(bus_err), 32'd0);
      chk("t6_async_dm_rdata", dm_rdata, 32'h0);
      chk("t6_async_if_rdata", if_rdata, 32'h0);
      chk("t6_async_dm_stall", 32'(dm_stall), 32'd0);
      dm_req = 1'b0; dm_we = 1'b0;
      cyc(); reset = 1'b1;
      cyc(); if_req = 1'b1; if_addr = 32'h8; #1;
      chk("t6_post_if_stall", 32'(if_stall), 32'd1);
      cyc(); mem_ready = 1'b1; mem_rdata = NOP_INSTR; #1;
      chk("t6_post_mem_addr", mem_addr, 32'h8);
      chk("t6_post_mem_req", 32'(mem_req), 32'd1);
      cyc(); mem_ready = 1'b0; #1;
      chk("t6_post_if_valid", 32'(if_valid), 32'd1);
      chk("t6_post_if_rdata", if_rdata, NOP_INSTR);
      chk("t6_post_bus_err", 32'(bus_err), 32'd0);
      if_req = 1'b0;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
